bullet_engine: RTL

BULLET_ENGINE -- requirements
Module: bullet_engine

---
 rtl/bullet_engine.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/bullet_engine.sv
// Two-bullet projectile engine: spawns, moves and hit-tests one bullet per player.
// Bullet 1 travels +x toward player 2; bullet 2 travels -x toward player 1.
module bullet_engine #(
  parameter int SCREEN_W = 640,
  parameter int PLAYER_W = 16,
  parameter int PLAYER_H = 32,
  parameter int P1_X     = 16,
  parameter int P2_X     = 608,
  parameter int SPEED    = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       frame_tick_i,
  input  logic       is_playing_i,
  input  logic       game_reset_i,
  input  logic       fire_1_i,
  input  logic       fire_2_i,
  input  logic [9:0] player_1_y_i,
  input  logic [9:0] player_2_y_i,
  output logic       bullet_collide_player_1_o,
  output logic       bullet_collide_player_2_o,
  output logic       bullet_1_active_o,
  output logic       bullet_2_active_o,
  output logic [9:0] bullet_1_x_o,
  output logic [9:0] bullet_1_y_o,
  output logic [9:0] bullet_2_x_o,
  output logic [9:0] bullet_2_y_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FLY  = 2'd1,
    S_HIT  = 2'd2
  } bstate_t;

  bstate_t     st1, st2;
  logic [9:0]  x1, y1, x2, y2;
  logic        col1, col2;
  logic        fire1_q, fire2_q;
  logic        pend1, pend2;
  logic        rise1, rise2;
  logic        pend1_eff, pend2_eff;
  logic [10:0] nx1, nx2;
  logic        hit1, hit2, off1, off2;
  logic        step;

  assign rise1     = fire_1_i & ~fire1_q;
  assign rise2     = fire_2_i & ~fire2_q;
  assign pend1_eff = pend1 | rise1;
  assign pend2_eff = pend2 | rise2;
  assign step      = frame_tick_i & is_playing_i;

  // next_x is one bit wider so +x overflow and -x underflow never alias into the playfield
  always_comb begin
    nx1  = {1'b0, x1} + 11'(SPEED);
    nx2  = {1'b0, x2} - 11'(SPEED);
    hit1 = (nx1 >= 11'(P2_X)) && (nx1 < 11'(P2_X + PLAYER_W)) &&
           ({1'b0, y1} >= {1'b0, player_2_y_i}) &&
           ({1'b0, y1} <  ({1'b0, player_2_y_i} + 11'(PLAYER_H)));
    hit2 = (nx2 >= 11'(P1_X)) && (nx2 < 11'(P1_X + PLAYER_W)) &&
           ({1'b0, y2} >= {1'b0, player_1_y_i}) &&
           ({1'b0, y2} <  ({1'b0, player_1_y_i} + 11'(PLAYER_H)));
    off1 = (nx1 >= 11'(SCREEN_W));
    off2 = (x2 < 10'(SPEED));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fire1_q <= 1'b0;
      fire2_q <= 1'b0;
      pend1   <= 1'b0;
      pend2   <= 1'b0;
    end else begin
      fire1_q <= fire_1_i;
      fire2_q <= fire_2_i;
      if (game_reset_i || frame_tick_i) begin
        pend1 <= 1'b0;
        pend2 <= 1'b0;
      end else begin
        pend1 <= pend1_eff;
        pend2 <= pend2_eff;
      end
    end
  end

  // Bullet 1 FSM; owns the "player 2 was hit" flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st1  <= S_IDLE;
      x1   <= '0;
      y1   <= '0;
      col2 <= 1'b0;
    end else if (game_reset_i) begin
      st1  <= S_IDLE;
      x1   <= '0;
      y1   <= '0;
      col2 <= 1'b0;
    end else if (step) begin
      case (st1)
        S_IDLE: begin
          if (pend1_eff) begin
            st1 <= S_FLY;
            x1  <= 10'(P1_X + PLAYER_W);
            y1  <= player_1_y_i + 10'(PLAYER_H / 2);
          end
        end
        S_FLY: begin
          if (hit1) begin
            st1  <= S_HIT;
            col2 <= 1'b1;
          end else if (off1) begin
            st1 <= S_IDLE;
            x1  <= '0;
            y1  <= '0;
          end else begin
            x1 <= nx1[9:0];
          end
        end
        S_HIT:   st1 <= S_HIT;
        default: st1 <= S_IDLE;
      endcase
    end
  end

  // Bullet 2 FSM; owns the "player 1 was hit" flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st2  <= S_IDLE;
      x2   <= '0;
      y2   <= '0;
      col1 <= 1'b0;
    end else if (game_reset_i) begin
      st2  <= S_IDLE;
      x2   <= '0;
      y2   <= '0;
      col1 <= 1'b0;
    end else if (step) begin
      case (st2)
        S_IDLE: begin
          if (pend2_eff) begin
            st2 <= S_FLY;
            x2  <= 10'(P2_X - 1);
            y2  <= player_2_y_i + 10'(PLAYER_H / 2);
          end
        end
        S_FLY: begin
          if (hit2) begin
            st2  <= S_HIT;
            col1 <= 1'b1;
          end else if (off2) begin
            st2 <= S_IDLE;
            x2  <= '0;
            y2  <= '0;
          end else begin
            x2 <= nx2[9:0];
          end
        end
        S_HIT:   st2 <= S_HIT;
        default: st2 <= S_IDLE;
      endcase
    end
  end

  assign bullet_1_active_o         = (st1 == S_FLY);
  assign bullet_2_active_o         = (st2 == S_FLY);
  assign bullet_1_x_o              = x1;
  assign bullet_1_y_o              = y1;
  assign bullet_2_x_o              = x2;
  assign bullet_2_y_o              = y2;
  assign bullet_collide_player_1_o = col1;
  assign bullet_collide_player_2_o = col2;

endmodule
